inv_sub_shift_serial: RTL and testbench

INV_SUB_SHIFT_SERIAL -- requirements
Module: inv_sub_shift_serial

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/inv_sub_shift_serial_if.sv | 27 ++
 rtl/inv_sbox.sv | 13 +
 rtl/inv_sub_shift_serial.sv | 116 +++++++++++
 tb/tb_inv_sub_shift_serial.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse SubBytes/ShiftRows datapath.
//   AES_STATE_W / AES_BYTES : state geometry
//   state_e                 : sequencing FSM states
//   INV_SBOX                : 256-entry inverse S-box
//   src_index()             : output byte -> source byte mapping of InvShiftRows
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Output byte 4c+r is fed from source byte 4*((c-r) mod 4)+r.
    // The 2-bit subtraction wraps naturally, giving the mod 4.
    function automatic logic [3:0] src_index(input logic [3:0] k);
        logic [1:0] col;
        logic [1:0] row;
        col = k[3:2];
        row = k[1:0];
        return {2'(col - row), row};
    endfunction

endpackage

// File: rtl/inv_sub_shift_serial_if.sv
// Handshake bundle for inv_sub_shift_serial.
//   in_valid / in_ready / in_state     : state input channel
//   out_valid / out_ready / out_state  : result output channel
//   busy                               : block is processing or holding a result
// slave modport is the block's view; master is the upstream/downstream view.
interface inv_sub_shift_serial_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [0:AES_STATE_W-1] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:AES_STATE_W-1] out_state;
    logic                   busy;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
//   din  : input byte
//   dout : InvSubBytes(din)
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_shift_serial.sv
// Serial InvShiftRows + InvSubBytes over one 128-bit AES state.
// A state is captured, then BYTES_PER_CYCLE result bytes are produced per
// cycle through that many inverse S-boxes; the full result is held until
// the downstream stage takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave view), see inv_sub_shift_serial_if
//
// state | meaning
// IDLE  | ready for a new state; capture on in_valid
// RUN   | writing BYTES_PER_CYCLE result bytes per cycle
// DONE  | result presented on out_state until out_ready
module inv_sub_shift_serial
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_sub_shift_serial_if.slave bus
);

    localparam int         RUN_CYCLES = AES_BYTES / BYTES_PER_CYCLE;
    localparam logic [3:0] CNT_LAST   = 4'(RUN_CYCLES - 1);

    state_e                      state;
    state_e                      state_nxt;
    logic [3:0]                  cnt;
    logic [0:AES_BYTES-1][7:0]   src_buf;
    logic [0:AES_BYTES-1][7:0]   result;
    logic                        accept;
    logic                        step;
    logic                        last;

    logic [3:0] lane_idx [BYTES_PER_CYCLE];
    logic [7:0] lane_in  [BYTES_PER_CYCLE];
    logic [7:0] lane_out [BYTES_PER_CYCLE];

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                // Returning to IDLE here means a new state is only taken on the following edge.
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                bus.busy  = 1'b0;
            end
        endcase
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        assign lane_idx[j] = 4'(int'(cnt) * BYTES_PER_CYCLE + j);
        assign lane_in[j]  = src_buf[src_index(lane_idx[j])];

        inv_sbox u_inv_sbox (
            .din  (lane_in[j]),
            .dout (lane_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            src_buf <= '0;
            result  <= '0;
        end else if (accept) begin
            src_buf <= bus.in_state;
            cnt     <= '0;
        end else if (step) begin
            for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                result[lane_idx[l]] <= lane_out[l];
            end
            // Hold on the last count; the next accept clears it.
            if (!last) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign bus.out_state = result;

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// Scoreboard bench: two instances (1 and 4 bytes per cycle) driven with
// directed vectors; a negedge monitor pops expected results on each transfer.
module tb_inv_sub_shift_serial;

    typedef logic [0:127] st_t;

    localparam st_t V63    = {16{8'h63}};
    localparam st_t V16    = {16{8'h16}};
    localparam st_t V52    = {16{8'h52}};
    localparam st_t E00    = {16{8'h00}};
    localparam st_t EFF    = {16{8'hff}};
    localparam st_t E48    = {16{8'h48}};
    localparam st_t V_SEQ  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam st_t E_SEQ  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam st_t V_ROW1 = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    localparam st_t E_ROW1 = 128'h101d1a1714111e1b1815121f1c191613;

    localparam int LAT    [2] = '{17, 5};
    localparam int PERIOD [2] = '{18, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n     [2];
    logic in_valid  [2];
    st_t  in_state  [2];
    logic out_ready [2];
    logic ir        [2];
    logic ov        [2];
    logic bsy       [2];
    st_t  os        [2];

    inv_sub_shift_serial_if bus1_if ();
    inv_sub_shift_serial_if bus4_if ();

    assign bus1_if.in_valid  = in_valid[0];
    assign bus1_if.in_state  = in_state[0];
    assign bus1_if.out_ready = out_ready[0];
    assign ir[0]  = bus1_if.in_ready;
    assign ov[0]  = bus1_if.out_valid;
    assign bsy[0] = bus1_if.busy;
    assign os[0]  = bus1_if.out_state;

    assign bus4_if.in_valid  = in_valid[1];
    assign bus4_if.in_state  = in_state[1];
    assign bus4_if.out_ready = out_ready[1];
    assign ir[1]  = bus4_if.in_ready;
    assign ov[1]  = bus4_if.out_valid;
    assign bsy[1] = bus4_if.busy;
    assign os[1]  = bus4_if.out_state;

    inv_sub_shift_serial #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n[0]),
        .bus   (bus1_if)
    );

    inv_sub_shift_serial #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n[1]),
        .bus   (bus4_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    st_t q0 [$];
    st_t q1 [$];

    function automatic void push_exp(input int d, input st_t v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic st_t pop_exp(input int d);
        if (d == 0) return q0.pop_front();
        else        return q1.pop_front();
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor state
    int  ncyc = 0;
    bit  pend      [2];
    int  edges     [2];
    bit  prev_ov   [2];
    bit  prev_ordy [2];
    st_t held      [2];
    int  ntrans    [2];
    bit  have_last [2];
    int  last_acc  [2];
    bit  b2b_mode  [2];
    st_t mon_exp;

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; edges[d] = 0; prev_ov[d] = 0; prev_ordy[d] = 0;
            held[d] = '0; ntrans[d] = 0; have_last[d] = 0; last_acc[d] = 0;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                pend[d]      = 0;
                prev_ov[d]   = 0;
                have_last[d] = 0;
            end else begin
                if (pend[d]) begin
                    edges[d]++;
                    if (ov[d]) begin
                        check((d == 0) ? "latency_bpc1" : "latency_bpc4", edges[d], LAT[d]);
                        pend[d] = 0;
                    end
                end
                if (ov[d]) begin
                    check("in_ready_in_done", ir[d], 1'b0);
                    check("busy_in_done", bsy[d], 1'b1);
                    if (prev_ov[d] && !prev_ordy[d]) begin
                        check("out_state_hold", os[d], held[d]);
                    end
                    held[d] = os[d];
                    if (out_ready[d]) begin
                        ntrans[d]++;
                        if (qsize(d) == 0) begin
                            check("unexpected_output", os[d], 128'hx);
                        end else begin
                            mon_exp = pop_exp(d);
                            check((d == 0) ? "out_state_bpc1" : "out_state_bpc4", os[d], mon_exp);
                        end
                    end
                end
                prev_ov[d]   = ov[d];
                prev_ordy[d] = out_ready[d];
                if (in_valid[d] && ir[d]) begin
                    pend[d]  = 1;
                    edges[d] = 0;
                    if (b2b_mode[d] && have_last[d]) begin
                        check("b2b_period", ncyc - last_acc[d], PERIOD[d]);
                    end
                    have_last[d] = b2b_mode[d];
                    last_acc[d]  = ncyc;
                end
            end
        end
    end

    task automatic send(input int d, input st_t data, input st_t expv);
        int n;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        in_state[d] = data;
        n = 0;
        @(negedge clk);
        while (!ir[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", ir[d], 1'b1);
        push_exp(d, expv);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", qsize(d), 0);
        @(negedge clk);
    endtask

    task automatic b2b(input int d, input st_t vin [3], input st_t vexp [3]);
        int n;
        b2b_mode[d]  = 1'b1;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        in_state[d] = vin[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            @(negedge clk);
            while (!ir[d] && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept", ir[d], 1'b1);
            push_exp(d, vexp[i]);
            @(posedge clk); #1;
            if (i < 2) in_state[d] = vin[i + 1];
            else       in_valid[d] = 1'b0;
        end
        drain(d);
        b2b_mode[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t bin  [3];
        st_t bexp [3];
        int  n;
        int  t0;

        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b1;
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b1;
            b2b_mode[d]  = 1'b0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", ir[d], 1'b1);
            check("rst_out_valid", ov[d], 1'b0);
            check("rst_busy", bsy[d], 1'b0);
            check("rst_out_state", os[d], '0);
        end

        // 4-byte instance: state presented during reset, taken on first edge after release
        in_valid[1] = 1'b1;
        in_state[1] = V16;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("first_accept_ready", ir[1], 1'b1);
        push_exp(1, EFF);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;

        // 1-byte instance: basic vectors
        send(0, V63, E00);
        send(0, V_SEQ, E_SEQ);
        drain(0);

        // Backpressure in DONE
        out_ready[0] = 1'b0;
        send(0, V_ROW1, E_ROW1);
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", ov[0], 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid[0] = i[0];
            in_state[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            check("bp_in_ready", ir[0], 1'b0);
        end
        t0 = ntrans[0];
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_one_transfer", ntrans[0] - t0, 1);
        check("bp_back_idle", ir[0], 1'b1);
        drain(0);

        // Reset in the middle of RUN
        send(0, V52, E48);
        repeat (6) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        check("mid_rst_out_valid", ov[0], 1'b0);
        check("mid_rst_busy", bsy[0], 1'b0);
        check("mid_rst_in_ready", ir[0], 1'b1);
        check("mid_rst_out_state", os[0], '0);
        void'(q0.pop_back());
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        send(0, V_SEQ, E_SEQ);
        drain(0);

        // Back-to-back, 1 byte per cycle
        bin[0] = V63;  bexp[0] = E00;
        bin[1] = V_SEQ; bexp[1] = E_SEQ;
        bin[2] = V52;  bexp[2] = E48;
        b2b(0, bin, bexp);

        // 4-byte instance
        drain(1);
        send(1, V_SEQ, E_SEQ);
        drain(1);
        bin[0] = V63;   bexp[0] = E00;
        bin[1] = V_ROW1; bexp[1] = E_ROW1;
        bin[2] = V16;   bexp[2] = EFF;
        b2b(1, bin, bexp);

        repeat (3) @(negedge clk);
        check("transfers_bpc1", ntrans[0], 7);
        check("transfers_bpc4", ntrans[1], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
